// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and helpers for the sync_fifo slice.
//   DATA_WIDTH_DEF / DEPTH_DEF / RAM_DEPTH_DEF : default parameter values.
//   ptr_width()                                : pointer width for a given RAM depth.
package fifo_pkg;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int DEPTH_DEF      = 32;
   localparam int RAM_DEPTH_DEF  = 32;

   // $clog2 of the storage depth. The result is clamped to 1 so that a
   // single-entry RAM still gets a legal vector width.
   function automatic int ptr_width(input int ram_depth);
      return (ram_depth > 1) ? $clog2(ram_depth) : 1;
   endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: RAM_DEPTH x DATA_WIDTH simple dual-port storage.
//   clk, rst      : clock, async active-low reset (clears only the read register)
//   we/waddr/wdata: synchronous write port
//   re/raddr      : read request; rdata is registered and holds when re=0
// The storage array itself is never reset.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int RAM_DEPTH  = RAM_DEPTH_DEF,
   parameter int AW         = ptr_width(RAM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)    rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock circular-buffer FIFO with registered read.
//   clk, rst (async, active low)
//   wr_en/data_in             : write side, accepted when not full
//   rd_en/data_out/valid      : read side, data and valid one cycle after rd_en
//   empty/full/almost_empty/almost_full : decodes of the occupancy count
//   overflow/underflow        : error indications for rejected requests
//   fifo_count                : occupancy 0..RAM_DEPTH
// Build option: define FIFO_STICKY_ERR_EN to make overflow/underflow sticky
// until reset; otherwise they are single-cycle pulses.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = DEPTH_DEF,
   parameter int RAM_DEPTH  = RAM_DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_empty,
   output logic                  almost_full,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  valid,
   output logic [DEPTH:0]        fifo_count
);

   localparam int             PW       = ptr_width(RAM_DEPTH);
   localparam logic [PW-1:0]  PTR_ONE  = PW'(1);
   localparam logic [PW-1:0]  PTR_LAST = PW'(RAM_DEPTH - 1);
   localparam logic [DEPTH:0] CNT_ONE  = (DEPTH+1)'(1);
   localparam logic [DEPTH:0] CNT_FULL = (DEPTH+1)'(RAM_DEPTH);

   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [DEPTH:0] count;
   logic           wr_ok, rd_ok;

   // Flags are pure decodes of count so an async reset clears them at once.
   assign empty        = (count == '0);
   assign full         = (count == CNT_FULL);
   assign almost_empty = (count <= CNT_ONE);
   assign almost_full  = (count >= CNT_FULL - CNT_ONE);
   assign fifo_count   = count;

   // Each side is qualified against the pre-edge flags, independently.
   assign wr_ok = wr_en && !full;
   assign rd_ok = rd_en && !empty;

   fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .RAM_DEPTH  (RAM_DEPTH),
      .AW         (PW)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_ok),
      .waddr (wr_ptr),
      .wdata (data_in),
      .re    (rd_ok),
      .raddr (rd_ptr),
      .rdata (data_out)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         valid     <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
         if (rd_ok) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         valid <= rd_ok;
`ifdef FIFO_STICKY_ERR_EN
         overflow  <= overflow  | (wr_en && full);
         underflow <= underflow | (rd_en && empty);
`else
         overflow  <= wr_en && full;
         underflow <= rd_en && empty;
`endif
      end
   end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: randomized + directed bench for sync_fifo against a
// queue-based reference model; checks all outputs every falling edge.
module tb_sync_fifo;
   localparam int DW = 8;
   localparam int DP = 32;
   localparam int RD = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          wr_en = 1'b0, rd_en = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic [DW-1:0] data_out;
   logic          empty, full, almost_empty, almost_full;
   logic          overflow, underflow, valid;
   logic [DP:0]   fifo_count;

   int total = 0;
   int bad   = 0;

   sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DP), .RAM_DEPTH(RD)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
      .data_out(data_out), .empty(empty), .full(full),
      .almost_empty(almost_empty), .almost_full(almost_full),
      .overflow(overflow), .underflow(underflow), .valid(valid),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [DW-1:0] q[$];
   logic [DW-1:0] m_dout = '0;
   logic          m_valid = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
   int            m_wcnt = 0, m_rcnt = 0;

   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         q.delete();
         m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
         m_wcnt = 0; m_rcnt = 0;
      end else begin
         automatic bit is_full  = (q.size() == RD);
         automatic bit is_empty = (q.size() == 0);
         automatic bit wok = wr_en && !is_full;
         automatic bit rok = rd_en && !is_empty;
`ifdef FIFO_STICKY_ERR_EN
         m_ovf = m_ovf | (wr_en && is_full);
         m_udf = m_udf | (rd_en && is_empty);
`else
         m_ovf = wr_en && is_full;
         m_udf = rd_en && is_empty;
`endif
         m_valid = rok;
         if (rok) begin m_dout = q.pop_front(); m_rcnt++; end
         if (wok) begin q.push_back(data_in); m_wcnt++; end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      if (rst) begin
         automatic int n = q.size();
         chk("data_out", 32'(data_out), 32'(m_dout));
         chk("valid", 32'(valid), 32'(m_valid));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         chk("underflow", 32'(underflow), 32'(m_udf));
         chk("fifo_count", 32'(fifo_count), 32'(n));
         chk("empty", 32'(empty), 32'(n == 0));
         chk("full", 32'(full), 32'(n == RD));
         chk("almost_empty", 32'(almost_empty), 32'(n <= 1));
         chk("almost_full", 32'(almost_full), 32'(n >= RD - 1));
         chk("wr_ptr", 32'(dut.wr_ptr), 32'(m_wcnt % RD));
         chk("rd_ptr", 32'(dut.rd_ptr), 32'(m_rcnt % RD));
      end
   end

   // one clock of stimulus; returns at posedge+1 with outputs settled
   task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
      wr_en = w; rd_en = r; data_in = d;
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_aempty", 32'(almost_empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_afull", 32'(almost_full), 32'd0);
      chk("rst_dout", 32'(data_out), 32'd0);
      chk("rst_ptrs", 32'({dut.wr_ptr, dut.rd_ptr}), 32'd0);
      step(0, 0, 0);

      // fill 0x00..0x1F, one write every two cycles
      for (int i = 0; i < RD; i++) begin
         step(1, 0, 8'(i));
         if (i == RD - 2) begin
            chk("afull_at31", 32'(almost_full), 32'd1);
            chk("nfull_at31", 32'(full), 32'd0);
         end
         step(0, 0, 0);
      end
      chk("fill_count", 32'(fifo_count), 32'd32);
      chk("fill_full", 32'(full), 32'd1);
      step(1, 0, 8'hAA);
      chk("ovf_pulse", 32'(overflow), 32'd1);
      chk("ovf_count", 32'(fifo_count), 32'd32);
      step(0, 0, 0);

      // drain, expecting write order
      for (int i = 0; i < RD; i++) begin
         step(0, 1, 0);
         chk("drain_data", 32'(data_out), 32'(i));
         chk("drain_valid", 32'(valid), 32'd1);
         step(0, 0, 0);
         chk("drain_hold", 32'(data_out), 32'(i));
      end
      chk("drain_empty", 32'(empty), 32'd1);
      chk("drain_rdptr", 32'(dut.rd_ptr), 32'd0);

      // underflow on empty read
      step(0, 1, 0);
      chk("udf_pulse", 32'(underflow), 32'd1);
      chk("udf_valid", 32'(valid), 32'd0);
      chk("udf_dout", 32'(data_out), 32'h1F);
      chk("udf_count", 32'(fifo_count), 32'd0);
      step(0, 0, 0);

      // fill to 5 then simultaneous read/write
      for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h40 + i));
      for (int i = 0; i < 10; i++) begin
         step(1, 1, 8'(8'h50 + i));
         chk("rw_count", 32'(fifo_count), 32'd5);
         if (i == 0) chk("rw_first", 32'(data_out), 32'h40);
         if (i == 5) chk("rw_sixth", 32'(data_out), 32'h50);
      end

      // random traffic with shifting write/read bias to reach both extremes
      for (int n = 0; n < 2400; n++) begin
         automatic int pw = (n / 200) % 3 == 0 ? 85 : ((n / 200) % 3 == 1 ? 50 : 15);
         automatic int pr = 100 - pw;
         step(($urandom_range(99) < pw), ($urandom_range(99) < pr), 8'($urandom));
      end

      // async reset mid-fill at count 17
      while (fifo_count != 0) step(0, 1, 0);
      for (int i = 0; i < 17; i++) step(1, 0, 8'(8'h90 + i));
      chk("pre_rst_count", 32'(fifo_count), 32'd17);
      #2 rst = 1'b0;
      #1;
      chk("async_count", 32'(fifo_count), 32'd0);
      chk("async_empty", 32'(empty), 32'd1);
      chk("async_afull", 32'(almost_full), 32'd0);
      @(posedge clk); #1 rst = 1'b1;
      step(1, 0, 8'h77);
      step(0, 1, 0);
      chk("post_rst_data", 32'(data_out), 32'h77);
      chk("post_rst_valid", 32'(valid), 32'd1);
      step(0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock synchronous FIFO built from a circular buffer with separate write and read pointers.
- Accepts one word per cycle on wr_en and returns one word per cycle on rd_en, with a registered read.
- Exposes occupancy, status flags, and one-cycle error pulses.
- Used as a general rate-decoupling buffer between producer and consumer logic in the same clock domain.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- DEPTH, 32, sizing parameter for the occupancy port; fifo_count is DEPTH+1 bits wide.
- RAM_DEPTH, 32, number of storage entries (FIFO capacity). Must be a power of two and must satisfy RAM_DEPTH < 2^(DEPTH+1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  registered read data.
- empty  output  1  occupancy == 0.
- full  output  1  occupancy == RAM_DEPTH.
- almost_empty  output  1  occupancy <= 1.
- almost_full  output  1  occupancy >= RAM_DEPTH-1.
- overflow  output  1  one-cycle pulse: write requested while full.
- underflow  output  1  one-cycle pulse: read requested while empty.
- valid  output  1  one-cycle pulse: data_out holds a newly read word.
- fifo_count  output  DEPTH+1  current occupancy, 0..RAM_DEPTH.

Behaviour:
- Internal registers are named wr_ptr and rd_ptr, each $clog2(RAM_DEPTH) bits. The bench probes them hierarchically.
- Reset (rst=0, asynchronous) clears:
  - wr_ptr, rd_ptr and count to 0;
  - data_out to 0;
  - valid, overflow and underflow to 0.
- After reset: empty=1, almost_empty=1, full=0, almost_full=0. Memory contents are not reset.
- Write accept: wr_en && !full.
  - mem[wr_ptr] <= data_in at the clock edge.
  - wr_ptr increments and wraps from RAM_DEPTH-1 to 0.
- Read accept: rd_en && !empty.
  - data_out <= mem[rd_ptr] at the clock edge.
  - rd_ptr increments with wrap.
  - valid=1 in the following cycle only.
- Read latency: data appears on data_out one clock after the rd_en edge. data_out holds its value when no read is accepted.
- Occupancy update:
  - count+1 on write only;
  - count-1 on read only;
  - unchanged when both or neither are accepted.
- Simultaneous wr_en and rd_en:
  - Each is qualified independently against the pre-edge flags.
  - When full: the read is accepted, the write is rejected with an overflow pulse, and count decrements.
  - When empty: the write is accepted, the read is rejected with an underflow pulse, and count increments.
  - Otherwise both are accepted and count is unchanged.
- overflow is registered: 1 in the cycle after an edge where wr_en && full, else 0. A rejected write does not modify memory or pointers.
- underflow is registered: 1 in the cycle after an edge where rd_en && empty, else 0. data_out is unchanged and valid stays 0.
- empty, full, almost_empty and almost_full are combinational decodes of the count register. fifo_count drives count directly.
- Reset asserted mid-operation discards all contents immediately. The flags return to their reset values without waiting for a clock.

Optional Feature:
- Macro: FIFO_STICKY_ERR_EN.
- Defined: overflow and underflow become sticky. Once set they stay 1 until reset, and new events keep them set.
- Undefined: both are single-cycle pulses as described above.
- All other behaviour is identical in both builds.

Decomposition:
- Package fifo_pkg holds:
  - default constants DATA_WIDTH_DEF=8, DEPTH_DEF=32 and RAM_DEPTH_DEF=32;
  - the function computing pointer width, $clog2(RAM_DEPTH).
- One natural sub-module, fifo_ram: a RAM_DEPTH x DATA_WIDTH simple dual-port array with a synchronous write port and a registered read port.
- The top level contains pointers, count, flags and error logic.

Test Plan:
- Reset, then idle -> empty=1, almost_empty=1, full=0, almost_full=0, fifo_count=0, data_out=0, wr_ptr=rd_ptr=0.
- Write 0x00..0x1F, one per two cycles -> fifo_count=32, full=1, and almost_full=1 from count 31. A further wr_en gives overflow=1 for one cycle, and count stays 32.
- Read 32 words, one per two cycles -> data_out sequence 0x00..0x1F, each one cycle after rd_en with valid=1. empty=1 at the end, and rd_ptr has wrapped to 0.
- rd_en on an empty FIFO -> underflow=1 for one cycle, valid=0, data_out unchanged, count 0.
- Fill to 5, then 10 cycles of simultaneous wr_en/rd_en -> fifo_count stays 5, and reads return words in write order across pointer wrap.
- Assert rst low mid-fill at count 17 -> fifo_count=0 and empty=1 before the next clock edge. The next write/read returns the new data.
